integer_retirement_unit: RTL

- Retirement-side counterpart to the integer issue classification.
- Accepts each issued instruction's retiring stage, functional unit and destination, and tracks it through the X1/X2 pipeline slots.
- Drives the issue stall for RAW and write-port hazards, and selects which functional-unit result commits through the single writeback port each cycle.

---
 rtl/integer_retirement_unit_pkg.sv | 28 ++
 rtl/integer_retirement_unit_hazard.sv | 39 +++
 rtl/integer_retirement_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/integer_retirement_unit_pkg.sv
// Shared control header for the integer retirement unit: word widths, functional
// unit encoding and the in-flight X1/X2 slot entry.
package integer_retirement_unit_pkg;

  localparam int TIA_WORD_WIDTH  = 32;
  localparam int IRU_NUM_REGISTERS = 8;
  localparam int IRU_INDEX_WIDTH = $clog2(IRU_NUM_REGISTERS);

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_SM  = 2'd1,
    FU_IMU = 2'd2
  } functional_unit_t;

  typedef struct packed {
    logic                       valid;
    logic [1:0]                 retiring_stage;
    functional_unit_t           functional_unit;
    logic                       destination_valid;
    logic [IRU_INDEX_WIDTH-1:0] destination_index;
  } in_flight_entry_t;

  // Anything other than an explicit stage 2 retires in X1.
  function automatic logic [1:0] normalize_stage(input logic [2:0] stage);
    return (stage == 3'd2) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/integer_retirement_unit_hazard.sv
// Combinational issue-stall generation: RAW hazards against both in-flight slots
// and the single-writeback-port conflict between a new stage-1 op and a stage-2 op in X1.
module integer_hazard_detector
  import integer_retirement_unit_pkg::*;
(
  input  in_flight_entry_t           x1_entry,
  input  in_flight_entry_t           x2_entry,
  input  logic                       issue_valid,
  input  logic [2:0]                 issue_retiring_stage,
  input  logic                       issue_source_0_valid,
  input  logic [IRU_INDEX_WIDTH-1:0] issue_source_0_index,
  input  logic                       issue_source_1_valid,
  input  logic [IRU_INDEX_WIDTH-1:0] issue_source_1_index,
  output logic                       issue_stall
);

  function automatic logic raw_hit(input in_flight_entry_t entry,
                                   input logic s0_valid, input logic [IRU_INDEX_WIDTH-1:0] s0,
                                   input logic s1_valid, input logic [IRU_INDEX_WIDTH-1:0] s1);
    return entry.valid && entry.destination_valid &&
           ((s0_valid && (s0 == entry.destination_index)) ||
            (s1_valid && (s1 == entry.destination_index)));
  endfunction

  logic raw_hazard;
  logic port_hazard;

  always_comb begin
    raw_hazard = raw_hit(x1_entry, issue_source_0_valid, issue_source_0_index,
                         issue_source_1_valid, issue_source_1_index) ||
                 raw_hit(x2_entry, issue_source_0_valid, issue_source_0_index,
                         issue_source_1_valid, issue_source_1_index);
    // Port conflict ignores destination_valid: the commit port also carries non-register updates.
    port_hazard = (normalize_stage(issue_retiring_stage) == 2'd1) &&
                  x1_entry.valid && (x1_entry.retiring_stage == 2'd2);
    issue_stall = issue_valid && (raw_hazard || port_hazard);
  end

endmodule

// File: rtl/integer_retirement_unit.sv
// Integer retirement unit: X1/X2 in-flight slots, writeback port selection and issue stall.
// Optional retirement/stall counters are enabled with INTEGER_RETIREMENT_COUNTERS_EN.
module integer_retirement_unit
  import integer_retirement_unit_pkg::*;
#(
  parameter int NUM_REGISTERS = IRU_NUM_REGISTERS,
  localparam int REGISTER_INDEX_WIDTH = $clog2(NUM_REGISTERS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            issue_valid,
  input  logic [2:0]                      issue_retiring_stage,
  input  functional_unit_t                issue_functional_unit,
  input  logic                            issue_destination_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] issue_destination_index,
  input  logic                            issue_source_0_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] issue_source_0_index,
  input  logic                            issue_source_1_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] issue_source_1_index,
  output logic                            issue_stall,
  input  logic [TIA_WORD_WIDTH-1:0]       alu_result,
  input  logic [TIA_WORD_WIDTH-1:0]       sm_result,
  input  logic [TIA_WORD_WIDTH-1:0]       imu_result,
  output logic                            writeback_valid,
  output logic [REGISTER_INDEX_WIDTH-1:0] writeback_index,
  output logic [TIA_WORD_WIDTH-1:0]       writeback_data,
  output logic                            quiescent
`ifdef INTEGER_RETIREMENT_COUNTERS_EN
  ,
  output logic [31:0]                     retired_count,
  output logic [31:0]                     stall_count
`endif
);

  in_flight_entry_t x1_entry;
  in_flight_entry_t x2_entry;
  logic             accept;
  logic             x1_retire;
  logic             x2_retire;

  integer_hazard_detector hazard (
    .x1_entry             (x1_entry),
    .x2_entry             (x2_entry),
    .issue_valid          (issue_valid),
    .issue_retiring_stage (issue_retiring_stage),
    .issue_source_0_valid (issue_source_0_valid),
    .issue_source_0_index (issue_source_0_index),
    .issue_source_1_valid (issue_source_1_valid),
    .issue_source_1_index (issue_source_1_index),
    .issue_stall          (issue_stall)
  );

  assign accept = issue_valid && !issue_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      x1_entry <= '0;
      x2_entry <= '0;
    end else begin
      if (accept) begin
        x1_entry.valid             <= 1'b1;
        x1_entry.retiring_stage    <= normalize_stage(issue_retiring_stage);
        x1_entry.functional_unit   <= issue_functional_unit;
        x1_entry.destination_valid <= issue_destination_valid;
        x1_entry.destination_index <= issue_destination_index;
      end else begin
        x1_entry <= '0;
      end
      if (x1_entry.valid && (x1_entry.retiring_stage == 2'd2)) begin
        x2_entry <= x1_entry;
      end else begin
        x2_entry <= '0;
      end
    end
  end

  assign x1_retire = x1_entry.valid && (x1_entry.retiring_stage == 2'd1);
  assign x2_retire = x2_entry.valid;
  assign quiescent = !x1_entry.valid && !x2_entry.valid;

  // Hazard rules keep x1 and x2 retirements disjoint, so priority order is arbitrary.
  always_comb begin
    writeback_valid = 1'b0;
    writeback_index = '0;
    writeback_data  = alu_result;
    if (x2_retire) begin
      writeback_valid = x2_entry.destination_valid;
      writeback_index = x2_entry.destination_index;
      case (x2_entry.functional_unit)
        FU_SM:   writeback_data = sm_result;
        FU_IMU:  writeback_data = imu_result;
        default: writeback_data = alu_result;
      endcase
    end else if (x1_retire) begin
      writeback_valid = x1_entry.destination_valid;
      writeback_index = x1_entry.destination_index;
      writeback_data  = alu_result;
    end
  end

`ifdef INTEGER_RETIREMENT_COUNTERS_EN
  // Saturating counters; retirements count even without a register destination.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_count <= '0;
      stall_count   <= '0;
    end else begin
      if ((x1_retire || x2_retire) && (retired_count != 32'hFFFF_FFFF)) begin
        retired_count <= retired_count + 32'd1;
      end
      if (issue_stall && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule
